adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_adder_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one 8-bit carry-lookahead adder, with a
// one-deep registered result slot and per-requester saturating grant counters.

module adder_arbiter_cla8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [7:0] gen_s;
  logic [7:0] prop_s;
  logic [2:0] c_lo_s;
  logic [2:0] c_hi_s;
  logic       c4_s;
  logic       c8_s;
  logic       grp_gen_lo_s;
  logic       grp_prop_lo_s;
  logic       grp_gen_hi_s;
  logic       grp_prop_hi_s;
  logic [7:0] carry_s;

  // Internal carries c1..c3 of a nibble, all in two-level lookahead form.
  function automatic logic [2:0] nibble_carries(input logic [3:0] g,
                                                input logic [3:0] p,
                                                input logic       ci);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    return c;
  endfunction

  function automatic logic group_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  function automatic logic group_prop(input logic [3:0] p);
    return &p;
  endfunction

  assign gen_s         = a & b;
  assign prop_s        = a ^ b;
  assign grp_gen_lo_s  = group_gen(gen_s[3:0], prop_s[3:0]);
  assign grp_prop_lo_s = group_prop(prop_s[3:0]);
  assign grp_gen_hi_s  = group_gen(gen_s[7:4], prop_s[7:4]);
  assign grp_prop_hi_s = group_prop(prop_s[7:4]);

  // Second-level lookahead: nibble carries come from group generate/propagate.
  assign c4_s   = grp_gen_lo_s | (grp_prop_lo_s & cin);
  assign c8_s   = grp_gen_hi_s | (grp_prop_hi_s & grp_gen_lo_s)
                | (grp_prop_hi_s & grp_prop_lo_s & cin);
  assign c_lo_s = nibble_carries(gen_s[3:0], prop_s[3:0], cin);
  assign c_hi_s = nibble_carries(gen_s[7:4], prop_s[7:4], c4_s);

  assign carry_s = {c_hi_s, c4_s, c_lo_s, cin};
  assign sum     = prop_s ^ carry_s;
  assign cout    = c8_s;

endmodule

module adder_arbiter #(
  parameter int FAIR = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req0_cin,
  input  logic       req0_sub,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       req1_cin,
  input  logic       req1_sub,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_sum,
  output logic       rsp_cout,
  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1
);

  logic       slot_free_s;
  logic       ready0_s;
  logic       ready1_s;
  logic       gnt_idx_s;
  logic       accept_s;
  logic       ptr_r;
  logic [7:0] sel_a_s;
  logic [7:0] sel_b_s;
  logic       sel_cin_s;
  logic       sel_sub_s;
  logic [7:0] add_b_s;
  logic       add_cin_s;
  logic [7:0] add_sum_s;
  logic       add_cout_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? 8'hFF : (cnt + 8'd1);
  endfunction

  assign slot_free_s = !rsp_valid || rsp_ready;

  // Grant selection; nothing is granted while in reset or while the slot is blocked.
  always_comb begin
    ready0_s  = 1'b0;
    ready1_s  = 1'b0;
    gnt_idx_s = 1'b0;
    if (rst_n && slot_free_s) begin
      case ({req1_valid, req0_valid})
        2'b01: begin
          ready0_s  = 1'b1;
          gnt_idx_s = 1'b0;
        end
        2'b10: begin
          ready1_s  = 1'b1;
          gnt_idx_s = 1'b1;
        end
        2'b11: begin
          if ((FAIR != 0) && ptr_r) begin
            ready1_s  = 1'b1;
            gnt_idx_s = 1'b1;
          end else begin
            ready0_s  = 1'b1;
            gnt_idx_s = 1'b0;
          end
        end
        default: begin
          ready0_s  = 1'b0;
          ready1_s  = 1'b0;
          gnt_idx_s = 1'b0;
        end
      endcase
    end else begin
      ready0_s  = 1'b0;
      ready1_s  = 1'b0;
      gnt_idx_s = 1'b0;
    end
  end

  assign accept_s   = ready0_s | ready1_s;
  assign req0_ready = ready0_s;
  assign req1_ready = ready1_s;

  // Operand steering for the single shared adder.
  always_comb begin
    if (gnt_idx_s) begin
      sel_a_s   = req1_a;
      sel_b_s   = req1_b;
      sel_cin_s = req1_cin;
      sel_sub_s = req1_sub;
    end else begin
      sel_a_s   = req0_a;
      sel_b_s   = req0_b;
      sel_cin_s = req0_cin;
      sel_sub_s = req0_sub;
    end
  end

  // Subtraction is A + ~B + 1, so cout=1 means no borrow.
  assign add_b_s   = sel_sub_s ? ~sel_b_s : sel_b_s;
  assign add_cin_s = sel_sub_s ? 1'b1 : sel_cin_s;

  adder_arbiter_cla8 u_cla (
    .a    (sel_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Round-robin pointer: after an accept it names the requester that lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (accept_s && (FAIR != 0)) begin
      ptr_r <= ~gnt_idx_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // One-deep result slot; reloads on accept, drains when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_sum   <= 8'h00;
      rsp_cout  <= 1'b0;
      rsp_id    <= 1'b0;
    end else if (accept_s) begin
      rsp_valid <= 1'b1;
      rsp_sum   <= add_sum_s;
      rsp_cout  <= add_cout_s;
      rsp_id    <= gnt_idx_s;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end else begin
      rsp_valid <= rsp_valid;
    end
  end

  // Saturating per-requester accept counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= 8'h00;
      gnt_cnt1 <= 8'h00;
    end else begin
      if (ready0_s) begin
        gnt_cnt0 <= sat_inc(gnt_cnt0);
      end else begin
        gnt_cnt0 <= gnt_cnt0;
      end
      if (ready1_s) begin
        gnt_cnt1 <= sat_inc(gnt_cnt1);
      end else begin
        gnt_cnt1 <= gnt_cnt1;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench: one round-robin and one fixed-priority instance share stimulus.

module tb_adder_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_cin, req0_sub, req1_cin, req1_sub;
  logic       rsp_ready;

  logic       rr_req0_ready, rr_req1_ready, rr_rsp_valid, rr_rsp_id, rr_rsp_cout;
  logic [7:0] rr_rsp_sum, rr_gnt_cnt0, rr_gnt_cnt1;
  logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_rsp_cout;
  logic [7:0] fp_rsp_sum, fp_gnt_cnt0, fp_gnt_cnt1;

  int checks = 0;
  int failures = 0;

  adder_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(rr_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(rr_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_sub(req1_sub),
    .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rr_rsp_id),
    .rsp_sum(rr_rsp_sum), .rsp_cout(rr_rsp_cout),
    .gnt_cnt0(rr_gnt_cnt0), .gnt_cnt1(rr_gnt_cnt1)
  );

  adder_arbiter #(.FAIR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin), .req1_sub(req1_sub),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id),
    .rsp_sum(fp_rsp_sum), .rsp_cout(fp_rsp_cout),
    .gnt_cnt0(fp_gnt_cnt0), .gnt_cnt1(fp_gnt_cnt1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_a = 8'h00; req0_b = 8'h00; req0_cin = 1'b0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = 8'h00; req1_b = 8'h00; req1_cin = 1'b0; req1_sub = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rr_valid"}, rr_rsp_valid, 1'b0);
    chk({tag, "_rr_sum"}, rr_rsp_sum, 8'h00);
    chk({tag, "_rr_cout"}, rr_rsp_cout, 1'b0);
    chk({tag, "_rr_id"}, rr_rsp_id, 1'b0);
    chk({tag, "_rr_cnt0"}, rr_gnt_cnt0, 8'h00);
    chk({tag, "_rr_cnt1"}, rr_gnt_cnt1, 8'h00);
    chk({tag, "_rr_rdy0"}, rr_req0_ready, 1'b0);
    chk({tag, "_rr_rdy1"}, rr_req1_ready, 1'b0);
    chk({tag, "_fp_valid"}, fp_rsp_valid, 1'b0);
    chk({tag, "_fp_rdy0"}, fp_req0_ready, 1'b0);
  endtask

  // Reset pulse with a live request presented, which must not be granted.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    req0_valid = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check_reset_values("rst");
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    clear_inputs();
    do_reset();

    // Single requester 0: 0x3C + 0x0F + 1 = 0x4C
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h0F; req0_cin = 1'b1; req0_sub = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("single_rdy0", rr_req0_ready, 1'b1);
    chk("single_rdy1", rr_req1_ready, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("single_valid", rr_rsp_valid, 1'b1);
    chk("single_sum", rr_rsp_sum, 8'h4C);
    chk("single_cout", rr_rsp_cout, 1'b0);
    chk("single_id", rr_rsp_id, 1'b0);
    chk("single_cnt0", rr_gnt_cnt0, 8'd1);
    @(posedge clk); #1;
    chk("drain_valid", rr_rsp_valid, 1'b0);

    // Both requesting: round-robin alternates, fixed priority always picks 0
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h01;
      req1_valid = 1'b1; req1_a = 8'h20; req1_b = 8'h02;
      rsp_ready = 1'b1;
      #1;
      chk($sformatf("rr_rdy0_%0d", i), rr_req0_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("rr_rdy1_%0d", i), rr_req1_ready, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("fp_rdy0_%0d", i), fp_req0_ready, 1'b1);
      chk($sformatf("fp_rdy1_%0d", i), fp_req1_ready, 1'b0);
      @(posedge clk); #1;
      chk($sformatf("rr_id_%0d", i), rr_rsp_id, (i % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("rr_sum_%0d", i), rr_rsp_sum, (i % 2 == 1) ? 8'h22 : 8'h11);
      chk($sformatf("fp_id_%0d", i), fp_rsp_id, 1'b0);
    end
    chk("rr_cnt0", rr_gnt_cnt0, 8'd2);
    chk("rr_cnt1", rr_gnt_cnt1, 8'd2);
    chk("fp_cnt0", fp_gnt_cnt0, 8'd4);
    chk("fp_cnt1", fp_gnt_cnt1, 8'd0);

    // Subtract on requester 1 (cin ignored), then stall the consumer
    do_reset();
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h07; req1_cin = 1'b1; req1_sub = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("sub_rdy1", rr_req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h40; req0_b = 8'h02; req0_cin = 1'b0; req0_sub = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_rdy0_%0d", i), rr_req0_ready, 1'b0);
      chk($sformatf("stall_rdy1_%0d", i), rr_req1_ready, 1'b0);
      chk($sformatf("stall_valid_%0d", i), rr_rsp_valid, 1'b1);
      chk($sformatf("stall_sum_%0d", i), rr_rsp_sum, 8'hFE);
      chk($sformatf("stall_cout_%0d", i), rr_rsp_cout, 1'b0);
      chk($sformatf("stall_id_%0d", i), rr_rsp_id, 1'b1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    chk("release_rdy0", rr_req0_ready, 1'b1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    chk("b2b_valid", rr_rsp_valid, 1'b1);
    chk("b2b_sum", rr_rsp_sum, 8'h42);
    chk("b2b_id", rr_rsp_id, 1'b0);
    chk("b2b_cnt1", rr_gnt_cnt1, 8'd1);
    @(posedge clk); #1;
    chk("b2b_drain", rr_rsp_valid, 1'b0);

    // 260 back-to-back accepts of requester 0: 0xFF + 0x01 wraps, counter saturates
    do_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h01; req0_cin = 1'b0; req0_sub = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 260; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        chk("wrap_sum", rr_rsp_sum, 8'h00);
        chk("wrap_cout", rr_rsp_cout, 1'b1);
      end
      if (i == 253) chk("sat_cnt0_254", rr_gnt_cnt0, 8'd254);
      if (i == 254) chk("sat_cnt0_255", rr_gnt_cnt0, 8'd255);
    end
    chk("sat_cnt0_hold", rr_gnt_cnt0, 8'd255);
    chk("sat_fp_cnt0", fp_gnt_cnt0, 8'd255);
    chk("sat_cnt1", rr_gnt_cnt1, 8'd0);

    // Asynchronous reset mid-cycle with a result held; pointer was left at 1
    @(negedge clk);
    req0_valid = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", rr_rsp_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    req1_valid = 1'b1;
    #1;
    check_reset_values("async");
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02; req0_cin = 1'b0; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'h08; req1_cin = 1'b0; req1_sub = 1'b0;
    #1;
    chk("post_rst_valid", rr_rsp_valid, 1'b0);
    chk("post_rst_rdy0", rr_req0_ready, 1'b1);
    chk("post_rst_rdy1", rr_req1_ready, 1'b0);
    @(posedge clk); #1;
    clear_inputs();
    chk("first_edge_valid", rr_rsp_valid, 1'b1);
    chk("first_edge_sum", rr_rsp_sum, 8'h03);
    chk("first_edge_id", rr_rsp_id, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
